fifo_rd_stream: RTL and testbench

Read-side adapter placed directly downstream of the team's synchronous FIFO. It drives the FIFO's read port (`rd_en`, registered `dout` valid one cycle after an accepted read, `empty` flag) and converts it into a valid/ready output stream. A small internal buffer absorbs the FIFO's read latency, so the stream sustains one word per cycle and never loses or duplicates a word under back-pressure.

---
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: issues credit-limited reads and
// turns the one-cycle-late dout into a valid/ready stream through a small ring buffer.
module fifo_rd_stream #(
  parameter int DWIDTH    = 16,
  parameter int BUF_DEPTH = 3,
  parameter int CWIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [CWIDTH-1:0] words_out
);

  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH_W  = (OW+1)'(BUF_DEPTH);

  logic [BUF_DEPTH-1:0][DWIDTH-1:0] mem;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [OW-1:0] occ;
  logic          pend;
  logic          pop;
  logic [OW:0]   credit_used;

  // An in-flight read already owns a slot, so it counts against the credit.
  always_comb begin
    credit_used = {1'b0, occ} + {{OW{1'b0}}, pend};
    fifo_rd_en  = !rst && en && !fifo_empty && (credit_used < DEPTH_W);
    m_valid     = (occ != '0);
    m_data      = mem[rd_idx];
    pop         = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      occ       <= '0;
      pend      <= 1'b0;
      words_out <= '0;
    end else begin
      pend <= fifo_rd_en;
      // dout is only meaningful in the cycle after an accepted read.
      if (pend) begin
        mem[wr_idx] <= fifo_dout;
        wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
      end
      if (pop) begin
        rd_idx    <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
        words_out <= words_out + CWIDTH'(1);
      end
      case ({pend, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioral FIFO read port model.
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [3:0]  words_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] fmem [0:255];
  int head = 0;
  int tail = 0;

  logic [15:0] rx [0:31];
  int rx_n = 0;

  fifo_rd_stream #(.DWIDTH(16), .BUF_DEPTH(3), .CWIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .words_out(words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered dout, garbage outside read-return cycles.
  assign fifo_empty = (head == tail);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fmem[head];
      head      <= head + 1;
    end else begin
      fifo_dout <= 16'hDEAD;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    fmem[tail] = d;
    tail = tail + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    repeat (2) cyc();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i));
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", m_data); end
    checks++; if (words_out !== 4'h0) begin errors++; $display("FAIL reset_words: got %h want 0", words_out); end
  endtask

  task automatic test_basic();
    rst = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_rd: got %b want 1", fifo_rd_en); end
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++;
      if (m_valid !== ((k >= 2) && (k <= 6))) begin
        errors++; $display("FAIL basic_valid k=%0d: got %b", k, m_valid);
      end
      if (k >= 2 && k <= 6) begin
        checks++;
        if (m_data !== 16'(k - 1)) begin errors++; $display("FAIL basic_data k=%0d: got %h want %h", k, m_data, 16'(k - 1)); end
      end
      checks++;
      if (fifo_rd_en !== (k <= 4)) begin errors++; $display("FAIL basic_rd_en k=%0d: got %b", k, fifo_rd_en); end
    end
    checks++; if (words_out !== 4'd5) begin errors++; $display("FAIL basic_words: got %0d want 5", words_out); end
  endtask

  task automatic test_stall();
    int nrd;
    nrd = 0;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    #1;
    for (int i = 0; i < 8; i++) begin
      if (fifo_rd_en) nrd++;
      if (i >= 2) begin
        checks++;
        if ({m_valid, m_data} !== {1'b1, 16'h0001}) begin
          errors++; $display("FAIL stall_hold i=%0d: got %b/%h want 1/0001", i, m_valid, m_data);
        end
      end
      cyc();
    end
    checks++; if (nrd !== 3) begin errors++; $display("FAIL stall_reads: got %0d want 3", nrd); end
    m_ready = 1'b1;
    rx_n = 0;
    #1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_full_rd: got %b want 0", fifo_rd_en); end
      end
      if (i == 1) begin
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stall_reissue: got %b want 1", fifo_rd_en); end
      end
      if (m_valid && m_ready) begin rx[rx_n] = m_data; rx_n++; end
      cyc();
    end
    checks++; if (rx_n !== 8) begin errors++; $display("FAIL stall_count: got %0d want 8", rx_n); end
    for (int j = 0; j < 8 && j < rx_n; j++) begin
      checks++;
      if (rx[j] !== 16'(j + 1)) begin errors++; $display("FAIL stall_order j=%0d: got %h want %h", j, rx[j], 16'(j + 1)); end
    end
    checks++; if (words_out !== 4'd13) begin errors++; $display("FAIL stall_words: got %0d want 13", words_out); end
  endtask

  task automatic test_toggle();
    logic        hold;
    logic [15:0] hold_data;
    hold = 1'b0; hold_data = '0;
    rx_n = 0;
    for (int i = 0; i < 6; i++) push(16'h0011 + 16'(i));
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 2 == 0);
      #1;
      if (hold) begin
        checks++;
        if ({m_valid, m_data} !== {1'b1, hold_data}) begin
          errors++; $display("FAIL toggle_stable i=%0d: got %b/%h want 1/%h", i, m_valid, m_data, hold_data);
        end
      end
      hold = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin rx[rx_n] = m_data; rx_n++; end
      cyc();
    end
    checks++; if (rx_n !== 6) begin errors++; $display("FAIL toggle_count: got %0d want 6", rx_n); end
    for (int j = 0; j < 6 && j < rx_n; j++) begin
      checks++;
      if (rx[j] !== 16'h0011 + 16'(j)) begin errors++; $display("FAIL toggle_order j=%0d: got %h want %h", j, rx[j], 16'h0011 + 16'(j)); end
    end
    checks++; if (words_out !== 4'd3) begin errors++; $display("FAIL toggle_words: got %0d want 3", words_out); end
  endtask

  task automatic test_en_drop();
    m_ready = 1'b1; en = 1'b1;
    push(16'h0021); push(16'h0022);
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL en_first_rd: got %b want 1", fifo_rd_en); end
    cyc();
    en = 1'b0;
    rx_n = 0;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL en_off_rd i=%0d: got %b want 0", i, fifo_rd_en); end
      if (m_valid && m_ready) begin rx[rx_n] = m_data; rx_n++; end
      cyc();
    end
    checks++; if (rx_n !== 1 || rx[0] !== 16'h0021) begin errors++; $display("FAIL en_inflight: got n=%0d w=%h want 1/0021", rx_n, rx[0]); end
    en = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL en_resume: got %b want 1", fifo_rd_en); end
    for (int i = 0; i < 5; i++) begin
      if (m_valid && m_ready) begin rx[rx_n] = m_data; rx_n++; end
      cyc();
    end
    checks++; if (rx_n !== 2 || rx[1] !== 16'h0022) begin errors++; $display("FAIL en_second: got n=%0d w=%h want 2/0022", rx_n, rx[1]); end
    checks++; if (words_out !== 4'd5) begin errors++; $display("FAIL en_words: got %0d want 5", words_out); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0031 + 16'(i));
    #1;
    repeat (3) cyc();
    checks++; if ({m_valid, m_data} !== {1'b1, 16'h0031}) begin errors++; $display("FAIL rmid_pre: got %b/%h want 1/0031", m_valid, m_data); end
    rst = 1'b1;
    tail = head;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_forced_rd: got %b want 0", fifo_rd_en); end
    cyc();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", m_valid); end
    checks++; if (words_out !== 4'd0) begin errors++; $display("FAIL rmid_words: got %0d want 0", words_out); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_rd: got %b want 0", fifo_rd_en); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL rmid_data: got %h want 0000", m_data); end
    rst = 1'b0;
    push(16'h0041); push(16'h0042);
    m_ready = 1'b1;
    rx_n = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid && m_ready) begin rx[rx_n] = m_data; rx_n++; end
      cyc();
    end
    checks++; if (rx_n !== 2) begin errors++; $display("FAIL rmid_count: got %0d want 2", rx_n); end
    checks++; if (rx[0] !== 16'h0041 || rx[1] !== 16'h0042) begin errors++; $display("FAIL rmid_fresh: got %h %h want 0041 0042", rx[0], rx[1]); end
    checks++; if (words_out !== 4'd2) begin errors++; $display("FAIL rmid_words2: got %0d want 2", words_out); end
  endtask

  task automatic test_wrap();
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 13; i++) push(16'h0050 + 16'(i));
    #1;
    repeat (24) cyc();
    checks++; if (words_out !== 4'hF) begin errors++; $display("FAIL wrap_pre: got %h want F", words_out); end
    push(16'h0060);
    #1;
    repeat (6) cyc();
    checks++; if (words_out !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", words_out); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
